// File: rtl/run_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : run_sequencer_if
//  Description : Host-side and core-side handshake bundle for run_sequencer.
//                The master modport is the sequencer's view; the slave modport
//                is the view of the host plus the TopLevel core it launches.
//  Signals     : HostReq/NumRuns      host run request and run count
//                HostBusy/HostDone    sequence status back to the host
//                CoreStart/CoreAck    TopLevel Start/Ack handshake
//                LastCycles/TotalCycles/RunsDone/Timeout  run statistics
//  Revision    : 1.0  initial release
// ============================================================================
interface run_sequencer_if #(
    parameter int unsigned RUN_W = 4,
    parameter int unsigned CYC_W = 16,
    parameter int unsigned TOT_W = 24
);
    logic             HostReq;
    logic [RUN_W-1:0] NumRuns;
    logic             HostBusy;
    logic             HostDone;
    logic             CoreStart;
    logic             CoreAck;
    logic [CYC_W-1:0] LastCycles;
    logic [TOT_W-1:0] TotalCycles;
    logic [RUN_W-1:0] RunsDone;
    logic             Timeout;

    modport master (
        input  HostReq, NumRuns, CoreAck,
        output HostBusy, HostDone, CoreStart,
               LastCycles, TotalCycles, RunsDone, Timeout
    );

    modport slave (
        output HostReq, NumRuns, CoreAck,
        input  HostBusy, HostDone, CoreStart,
               LastCycles, TotalCycles, RunsDone, Timeout
    );
endinterface
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : run_sequencer
//  Description : Host-side launcher for TopLevel. Accepts a host run request,
//                issues NumRuns back-to-back Start/Ack handshakes to the core
//                and measures per-run and total execution cycles.
//  Ports       : Clk            system clock, rising edge
//                Reset          asynchronous, active-low
//                bus (master)   HostReq/NumRuns in, HostBusy/HostDone out,
//                               CoreStart out, CoreAck in,
//                               LastCycles/TotalCycles/RunsDone/Timeout out
//  Config      : RUN_WATCHDOG_EN  when defined, a run with no Ack after
//                TIMEOUT RUN clocks is aborted and Timeout is set (sticky).
//  Revision    : 1.0  initial release
// ============================================================================
module run_sequencer #(
    parameter int unsigned RUN_W   = 4,
    parameter int unsigned CYC_W   = 16,
    parameter int unsigned TOT_W   = 24,
    parameter int unsigned START_W = 1,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic            Clk,
    input  logic            Reset,
    run_sequencer_if.master bus
);

    localparam int unsigned         c_SCNT_W     = (START_W > 1) ? $clog2(START_W) : 1;
    localparam logic [c_SCNT_W-1:0] c_START_LAST = c_SCNT_W'(START_W - 1);

    if (START_W == 0) begin : g_chk_start_w
        $error("run_sequencer: START_W must be at least 1");
    end
    if (TIMEOUT == 0) begin : g_chk_timeout
        $error("run_sequencer: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q;
    logic                ack_q;
    logic [RUN_W-1:0]    num_runs_q;
    logic [RUN_W-1:0]    runs_done_q;
    logic [CYC_W-1:0]    last_cyc_q;
    logic [TOT_W-1:0]    total_q;
    logic [CYC_W-1:0]    cyc_q;
    logic [c_SCNT_W-1:0] scnt_q;
    logic                start_q;
    logic                busy_q;
    logic                done_q;

    logic                ack_rise_d;
    logic [CYC_W-1:0]    run_len_d;
    logic [TOT_W:0]      total_sum_d;
    logic [TOT_W-1:0]    total_d;
    logic                more_runs_d;

    // Only a rising Ack ends a run; a level left high by the previous run
    // (or raised during START) never counts as a completion.
    assign ack_rise_d  = bus.CoreAck & ~ack_q;
    // cyc_q holds the Ack-free RUN clocks so far; the Ack clock itself is one more.
    assign run_len_d   = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);
    assign total_sum_d = {1'b0, total_q} + {{(TOT_W + 1 - CYC_W){1'b0}}, run_len_d};
    assign total_d     = total_sum_d[TOT_W] ? {TOT_W{1'b1}} : total_sum_d[TOT_W-1:0];
    assign more_runs_d = ({1'b0, runs_done_q} + (RUN_W + 1)'(1)) < {1'b0, num_runs_q};

`ifdef RUN_WATCHDOG_EN
    localparam logic [CYC_W-1:0] c_WD_LAST = CYC_W'(TIMEOUT - 1);
    logic timeout_q;
    logic wd_hit_d;
    // The clock that would be RUN clock TIMEOUT, with no Ack rise on it.
    assign wd_hit_d = (cyc_q == c_WD_LAST);
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            ack_q       <= 1'b0;
            num_runs_q  <= '0;
            runs_done_q <= '0;
            last_cyc_q  <= '0;
            total_q     <= '0;
            cyc_q       <= '0;
            scnt_q      <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef RUN_WATCHDOG_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            ack_q <= bus.CoreAck;
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.HostReq) begin
                        num_runs_q  <= bus.NumRuns;
                        runs_done_q <= '0;
                        total_q     <= '0;
                        busy_q      <= 1'b1;
`ifdef RUN_WATCHDOG_EN
                        timeout_q   <= 1'b0;
`endif
                        if (bus.NumRuns == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_START;
                            start_q <= 1'b1;
                            scnt_q  <= '0;
                        end
                    end
                end

                S_START: begin
                    if (scnt_q == c_START_LAST) begin
                        state_q <= S_RUN;
                        start_q <= 1'b0;
                        cyc_q   <= '0;
                    end else begin
                        scnt_q <= scnt_q + c_SCNT_W'(1);
                    end
                end

                S_RUN: begin
                    if (ack_rise_d) begin
                        last_cyc_q  <= run_len_d;
                        total_q     <= total_d;
                        runs_done_q <= runs_done_q + RUN_W'(1);
                        if (more_runs_d) begin
                            state_q <= S_GAP;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
`ifdef RUN_WATCHDOG_EN
                    end else if (wd_hit_d) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
`endif
                    end else if (!(&cyc_q)) begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end

                S_GAP: begin
                    state_q <= S_START;
                    start_q <= 1'b1;
                    scnt_q  <= '0;
                end

                S_DONE: begin
                    // Entry from RUN already raised HostDone. A zero-run
                    // sequence enters with it low and spends one settle
                    // clock here before pulsing.
                    if (done_q) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    start_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HostBusy    = busy_q;
    assign bus.HostDone    = done_q;
    assign bus.CoreStart   = start_q;
    assign bus.LastCycles  = last_cyc_q;
    assign bus.TotalCycles = total_q;
    assign bus.RunsDone    = runs_done_q;
`ifdef RUN_WATCHDOG_EN
    assign bus.Timeout     = timeout_q;
`else
    assign bus.Timeout     = 1'b0;
`endif

endmodule
`default_nettype wire
